// File: rtl/pcihellocore_ledg_pkg.sv
// Shared definitions for the LEDG sequencer: register map, animation modes,
// FSM encoding and STATUS field layout.
package pcihellocore_ledg_pkg;

   localparam logic [1:0] ADDR_CTRL    = 2'd0;
   localparam logic [1:0] ADDR_PERIOD  = 2'd1;
   localparam logic [1:0] ADDR_PATTERN = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_ROTL   = 2'b01,
      MODE_ROTR   = 2'b10,
      MODE_INVERT = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_IDLE = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam int STATUS_CNT_LSB = 0;
   localparam int STATUS_CNT_W   = 16;
   localparam int STATUS_EN_BIT  = 16;

endpackage

// File: rtl/pcihellocore_ledg_step_timer.sv
// Tick counter for the sequencer: pulses tick on the last cycle of each step
// period while running; a PERIOD of 0 is treated as 1.
module pcihellocore_ledg_step_timer
   import pcihellocore_ledg_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [CNT_W-1:0] period,
   input  logic             run,
   input  logic             clear,
   output logic             tick
);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] last;

   assign last = (period == '0) ? '0 : period - CNT_W'(1);
   assign tick = run && (cnt_reg == last);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_reg <= '0;
      end else if (!run || clear || tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pcihellocore_ledg_sequencer.sv
// LEDG sequencer: host-programmable pattern animator that mirrors its pattern
// register into the LEDG PIO through single-cycle Avalon-MM writes.
module pcihellocore_ledg_sequencer
   import pcihellocore_ledg_pkg::*;
#(
   parameter int               WIDTH         = 32,
   parameter int               CNT_W         = 32,
   parameter logic [WIDTH-1:0] RESET_PATTERN = WIDTH'(15)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [1:0]       avm_address,
   output logic             avm_chipselect,
   output logic             avm_write_n,
   output logic [WIDTH-1:0] avm_writedata,
   output logic             step_pulse
);

   state_t                  state_reg, state_next;
   logic                    enable_reg, enable_next;
   mode_t                   mode_reg, mode_next;
   logic [CNT_W-1:0]        period_reg, period_next;
   logic [WIDTH-1:0]        pattern_reg, pattern_next;
   logic [STATUS_CNT_W-1:0] count_reg, count_next;
   logic                    strobe_reg, strobe_next;
   logic                    pulse_reg, pulse_next;

   logic wr, ctrl_wr, period_wr, pattern_wr, status_wr;
   logic tick, step;

   assign wr         = chipselect && !write_n;
   assign ctrl_wr    = wr && (address == ADDR_CTRL);
   assign period_wr  = wr && (address == ADDR_PERIOD);
   assign pattern_wr = wr && (address == ADDR_PATTERN);
   assign status_wr  = wr && (address == ADDR_STATUS);

   // Host writes to PATTERN or PERIOD pre-empt a coinciding terminal count.
   assign step = tick && !pattern_wr && !period_wr;

   pcihellocore_ledg_step_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .period  (period_reg),
      .run     (state_reg == ST_RUN),
      .clear   (period_wr || pattern_wr),
      .tick    (tick)
   );

   function automatic logic [WIDTH-1:0] next_pattern(input mode_t m, input logic [WIDTH-1:0] p);
      logic [WIDTH-1:0] r;
      case (m)
         MODE_ROTL:   r = {p[WIDTH-2:0], p[WIDTH-1]};
         MODE_ROTR:   r = {p[0], p[WIDTH-1:1]};
         MODE_INVERT: r = ~p;
         default:     r = p;
      endcase
      return r;
   endfunction

   always_comb begin
      state_next   = state_reg;
      enable_next  = enable_reg;
      mode_next    = mode_reg;
      period_next  = period_reg;
      pattern_next = pattern_reg;
      count_next   = count_reg;
      strobe_next  = 1'b0;
      pulse_next   = 1'b0;

      if (ctrl_wr) begin
         enable_next = writedata[0];
         mode_next   = mode_t'(writedata[2:1]);
      end
      if (period_wr) begin
         period_next = writedata[CNT_W-1:0];
      end
      if (step) begin
         count_next = count_reg + STATUS_CNT_W'(1);
         pulse_next = 1'b1;
         if (mode_reg != MODE_STATIC) begin
            pattern_next = next_pattern(mode_reg, pattern_reg);
            strobe_next  = 1'b1;
         end
      end
      if (pattern_wr) begin
         pattern_next = writedata[WIDTH-1:0];
         strobe_next  = 1'b1;
      end
      if (status_wr) begin
         count_next = '0;
      end

      case (state_reg)
         ST_SYNC: begin
            // Push the reset pattern so the PIO matches us after any reset.
            strobe_next = 1'b1;
            state_next  = enable_next ? ST_RUN : ST_IDLE;
         end
         ST_IDLE: if (enable_next) state_next = ST_RUN;
         ST_RUN:  if (!enable_next) state_next = ST_IDLE;
         default: state_next = ST_SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg   <= ST_SYNC;
         enable_reg  <= 1'b0;
         mode_reg    <= MODE_STATIC;
         period_reg  <= '0;
         pattern_reg <= RESET_PATTERN;
         count_reg   <= '0;
         strobe_reg  <= 1'b0;
         pulse_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         enable_reg  <= enable_next;
         mode_reg    <= mode_next;
         period_reg  <= period_next;
         pattern_reg <= pattern_next;
         count_reg   <= count_next;
         strobe_reg  <= strobe_next;
         pulse_reg   <= pulse_next;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CTRL:    readdata[2:0] = {mode_reg, enable_reg};
         ADDR_PERIOD:  readdata = 32'(period_reg);
         ADDR_PATTERN: readdata = 32'(pattern_reg);
         default: begin
            readdata[STATUS_CNT_LSB +: STATUS_CNT_W] = count_reg;
            readdata[STATUS_EN_BIT]                  = enable_reg;
         end
      endcase
   end

   assign avm_address    = 2'b00;
   assign avm_chipselect = strobe_reg;
   assign avm_write_n    = !strobe_reg;
   assign avm_writedata  = pattern_reg;
   assign step_pulse     = pulse_reg;

endmodule
